// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle sequencer in front of the 8-bit barrel shift stage.
// Breaks a wide shift amount into chunks of at most 7 and applies them one per
// cycle to an internal accumulator, with valid/ready handshakes on both sides.
// Optional feature macro: SHIFT_SEQ_SAT_EN (amounts >= DATA_WIDTH resolve in one step).
module shift_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AMT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [AMT_WIDTH-1:0]  in_amount,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  // Largest amount the combinational shift stage can apply in one pass.
  localparam logic [AMT_WIDTH-1:0] CHUNK_MAX = AMT_WIDTH'(7);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [AMT_WIDTH-1:0]  rem;
  logic [AMT_WIDTH-1:0]  rem_nxt;
  op_t                   op_q;
  op_t                   op_nxt;
  logic                  accept;
  logic [2:0]            chunk;
  logic                  last_chunk;
  logic                  skip_shift;

  // One pass through the barrel shift stage; SRA fills with the current MSB.
  function automatic logic [DATA_WIDTH-1:0] shift_by(
    input logic [DATA_WIDTH-1:0] v,
    input logic [2:0]            sh,
    input op_t                   op
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = v << sh;
      OP_SRL:  r = v >> sh;
      OP_SRA:  r = $unsigned($signed(v) >>> sh);
      default: r = v;
    endcase
    return r;
  endfunction

  assign accept     = in_valid & in_ready;
  assign last_chunk = (rem <= CHUNK_MAX);
  assign chunk      = last_chunk ? rem[2:0] : 3'd7;
  assign skip_shift = (in_amount == '0) || (op_t'(in_op) == OP_PASS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept, chunked shifting, result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (skip_shift) begin
            state_nxt = DONE;
          end else begin
`ifdef SHIFT_SEQ_SAT_EN
            if ({1'b0, in_amount} >= (AMT_WIDTH + 1)'(DATA_WIDTH)) begin
              state_nxt = DONE;
            end else begin
              state_nxt = SHIFT;
            end
`else
            state_nxt = SHIFT;
`endif
          end
        end
      end
      SHIFT: begin
        if (last_chunk) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: load on accept, one chunk per SHIFT cycle.
  always_comb begin
    acc_nxt = acc;
    rem_nxt = rem;
    op_nxt  = op_q;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt = in_data;
          rem_nxt = in_amount;
          op_nxt  = op_t'(in_op);
`ifdef SHIFT_SEQ_SAT_EN
          // Any amount past the operand width has a fixed outcome, so it is
          // resolved here instead of walking through the chunks.
          if (!skip_shift && ({1'b0, in_amount} >= (AMT_WIDTH + 1)'(DATA_WIDTH))) begin
            acc_nxt = (op_t'(in_op) == OP_SRA) ? {DATA_WIDTH{in_data[DATA_WIDTH-1]}} : '0;
            rem_nxt = '0;
          end
`endif
        end
      end
      SHIFT: begin
        acc_nxt = shift_by(acc, chunk, op_q);
        rem_nxt = rem - AMT_WIDTH'(chunk);
      end
      default: begin
        acc_nxt = acc;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= OP_SLL;
    end else begin
      acc  <= acc_nxt;
      rem  <= rem_nxt;
      op_q <= op_nxt;
    end
  end

  // Outputs are pure state decodes so reset takes effect without a clock.
  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
    out_result = acc;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amount;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       busy;

  int unsigned n_cmp;
  int unsigned n_fail;

  shift_seq_ctrl #(.DATA_WIDTH(8), .AMT_WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amount  (in_amount),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Result of shifting by the whole amount in one go, in plain integer arithmetic.
  function automatic logic [7:0] ref_res(input logic [7:0] d, input int a, input logic [1:0] op);
    int v;
    case (op)
      2'b00: v = int'(d) << a;
      2'b01: v = int'(d) >> a;
      2'b10: v = int'($signed(d)) >>> a;
      default: v = int'(d);
    endcase
    return v[7:0];
  endfunction

  // Edges from the accept edge to the first edge that sees out_valid high.
  function automatic int ref_lat(input int a, input logic [1:0] op);
    if (a == 0 || op == 2'b11) return 1;
`ifdef SHIFT_SEQ_SAT_EN
    if (a >= 8) return 1;
`endif
    return (a + 6) / 7 + 1;
  endfunction

  // Cycle-by-cycle compare against the transaction model (sampled at negedge).
  initial begin : compare
    int phase;       // 0 idle, 1 working, 2 result pending
    int cnt;
    logic [7:0] m_res;
    phase = 0;
    cnt   = 0;
    m_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
      end else begin
        chk("in_ready", in_ready, phase == 0);
        chk("out_valid", out_valid, phase == 2);
        chk("busy", busy, phase != 0);
        if (phase == 2) chk("out_result", out_result, m_res);
        case (phase)
          0: if (in_valid) begin
            m_res = ref_res(in_data, int'(in_amount), in_op);
            cnt   = ref_lat(int'(in_amount), in_op) - 1;
            phase = (cnt == 0) ? 2 : 1;
          end
          1: begin
            cnt--;
            if (cnt == 0) phase = 2;
          end
          default: if (out_ready) phase = 0;
        endcase
      end
    end
  end

  // Caller sits just after a posedge; returns just after the accept edge.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    if (!ok) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_result(input string name, input logic [7:0] exp_res, input int exp_lat,
                             output int busy_cycles);
    bit ok;
    int lat;
    logic [7:0] res;
    ok = 0;
    lat = 0;
    res = '0;
    busy_cycles = 0;
    while (!ok && lat < 50) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      ok  = out_valid;
      res = out_result;
      @(posedge clk);
      #2;
      lat++;
    end
    chk({name, "_result"}, res, exp_res);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_txn(input string name, input logic [7:0] d, input logic [4:0] a,
                         input logic [1:0] o, input logic [7:0] exp_res, input int exp_lat,
                         output int busy_cycles);
    in_valid  = 1;
    in_data   = d;
    in_amount = a;
    in_op     = o;
    out_ready = 1;
    wait_accept(name);
    in_valid  = 0;
    in_data   = 8'($urandom);
    in_amount = 5'($urandom);
    in_op     = 2'($urandom);
    wait_result(name, exp_res, exp_lat, busy_cycles);
  endtask

  initial begin : stim
    int bc;
    bit ok;
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 0;
    in_valid  = 0;
    in_data   = '0;
    in_amount = '0;
    in_op     = '0;
    out_ready = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #2;

    run_txn("sll_81_3", 8'h81, 5'd3, 2'b00, 8'h08, 2, bc);
    chk("sll_81_3_busy_cycles", bc, 2);
    run_txn("srl_f0_4", 8'hF0, 5'd4, 2'b01, 8'h0F, 2, bc);
`ifdef SHIFT_SEQ_SAT_EN
    run_txn("sra_90_10", 8'h90, 5'd10, 2'b10, 8'hFF, 1, bc);
    run_txn("sll_01_31", 8'h01, 5'd31, 2'b00, 8'h00, 1, bc);
    run_txn("srl_80_8", 8'h80, 5'd8, 2'b01, 8'h00, 1, bc);
`else
    run_txn("sra_90_10", 8'h90, 5'd10, 2'b10, 8'hFF, 3, bc);
    run_txn("sll_01_31", 8'h01, 5'd31, 2'b00, 8'h00, 6, bc);
    run_txn("srl_80_8", 8'h80, 5'd8, 2'b01, 8'h00, 3, bc);
`endif
    run_txn("sra_40_3", 8'h40, 5'd3, 2'b10, 8'h08, 2, bc);
    run_txn("sra_80_7", 8'h80, 5'd7, 2'b10, 8'hFF, 2, bc);
    run_txn("sll_5a_0", 8'h5A, 5'd0, 2'b00, 8'h5A, 1, bc);
    run_txn("pass_c3_20", 8'hC3, 5'd20, 2'b11, 8'hC3, 1, bc);
    chk("pass_c3_20_busy_cycles", bc, 1);

    // Backpressure with a second request waiting.
    in_valid  = 1;
    in_data   = 8'h80;
    in_amount = 5'd7;
    in_op     = 2'b01;
    out_ready = 0;
    wait_accept("bp1");
    in_data   = 8'h03;
    in_amount = 5'd2;
    in_op     = 2'b00;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("bp1_done_reached", ok, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_result", out_result, 8'h01);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1;
    @(negedge clk);
    chk("bp_pre_handshake_in_ready", in_ready, 0);
    chk("bp_pre_handshake_result", out_result, 8'h01);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("bp_idle_after_handshake", in_ready, 1);
    @(posedge clk);
    #2 in_valid = 0;
    wait_result("bp2", 8'h0C, 2, bc);

    // Asynchronous reset in the middle of a long shift.
    in_valid  = 1;
    in_data   = 8'hFF;
    in_amount = 5'd28;
    in_op     = 2'b01;
    out_ready = 1;
    wait_accept("rst_mid");
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_async_in_ready", in_ready, 1);
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_stale_result", out_valid, 0);
    end
    @(posedge clk);
    #2;
    run_txn("after_rst_sll_01_1", 8'h01, 5'd1, 2'b00, 8'h02, 2, bc);

    // Randomized traffic; the compare process tracks everything.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_amount = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 8)) : 5'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (20) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
